mac_array_seq: RTL and testbench
================================

// Module: mac_array_seq
// PURPOSE
//  Initiator-side sequencer for mac_array: reads K and Q vectors from a 1-cycle-latency vector memory
//  and drives the array's in/inst interface through a kernel load, drain, execute, drain sequence.
//  It sits between the vector SRAM and mac_array.in/mac_array.inst, which makes the traffic
//  hand-written in benches reproducible in silicon. One start pulse runs one full K x Q pass.
// PARAMETERS
//  NUM_K    8      K vectors loaded per pass (inst=01 cycles)
//  NUM_Q    8      Q vectors executed per pass (inst=10 cycles)
//  DRAIN    22     inst=00 cycles after the last 01 cycle and after the last 10 cycle (>=1)
//  AW       8      memory address width
//  BW       64     vector width (8 lanes x 8b, lane0 = bits[7:0])
//  K_BASE   0      address of K[0]; K[i] at K_BASE+i
//  Q_BASE   8      address of Q[0]; Q[j] at Q_BASE+j
// PORTS
//  clk         in   1   clock; all state on rising edge
//  reset       in   1   asynchronous, active-high; clears all state
//  start       in   1   begin a pass; sampled only in IDLE
//  k_reuse     in   1   sampled with start: 1 = skip LOAD_K/DRAIN_K, keep kernel already in the array
//  mem_rd      out  1   memory read strobe
//  mem_addr    out  AW  memory read address
//  mem_rdata   in   BW  read data, valid the cycle after mem_rd
//  array_in    out  BW  to mac_array.in
//  array_inst  out  2   to mac_array.inst: 00 idle, 01 load K, 10 execute Q, 11 never driven
//  busy        out  1   pass in progress
//  done        out  1   one-cycle pulse at end of pass
// BEHAVIOUR
//  - All outputs are registered. Reset values are 0: mem_rd, mem_addr, array_in, array_inst, busy,
//    done. FSM reset state is IDLE.
//  - FSM: IDLE -> LOAD_K -> DRAIN_K -> EXEC_Q -> DRAIN_Q -> DONE -> IDLE.
//    IDLE goes to EXEC_Q directly when k_reuse=1.
//  - Cycle c = 1 is the first cycle after the edge that sampled start=1 in IDLE.
//  - LOAD_K: mem_rd=1, mem_addr=K_BASE+i in cycle 1+i, i=0..NUM_K-1.
//    array_inst=01 in cycles 2..NUM_K+1. array_in=K[i] in cycle 3+i.
//    inst leads the matching data by exactly one cycle (array protocol).
//  - DRAIN_K: array_inst=00 for DRAIN cycles, NUM_K+2..NUM_K+1+DRAIN.
//  - EXEC_Q: P = NUM_K+2+DRAIN, or P = 2 when k_reuse. mem_rd=1, mem_addr=Q_BASE+j in cycle P-1+j.
//    array_inst=10 in cycles P..P+NUM_Q-1. array_in=Q[j] in cycle P+1+j.
//  - DRAIN_Q: array_inst=00 for DRAIN cycles. done=1 in the single cycle P+NUM_Q+DRAIN.
//    busy=1 from cycle 1 through the done cycle inclusive. State returns to IDLE after the done cycle.
//  - array_in is loaded only from read returns; otherwise it holds its last value.
//    mem_addr holds its last value when mem_rd=0.
//  - Phase counters use clog2(max(NUM_K,NUM_Q,DRAIN)+1) bits. Counters do not wrap within a phase;
//    each counter clears on phase exit.
//  - start while busy: ignored, no queuing. start held high: the next pass begins at the first IDLE
//    sample after done, so c=1 falls two cycles after the done cycle.
//  - k_reuse: sampled only with start; changes during a pass are ignored.
//  - reset mid-pass: outputs go to 0 immediately (asynchronous). No done pulse is produced.
//    A new start is required after reset deasserts.
//  - array_inst never carries 11. 01 and 10 never appear in adjacent cycles.
// TESTING
//  - Defaults, memory preloaded K[i]=i+1 per lane, Q[j]=0x10+j, start pulse at c=0 ->
//    mem_rd in cycles 1-8 and 31-38; inst=01 in 2-9; inst=10 in 32-39; K data in 3-10;
//    Q data in 33-40; done only in cycle 62; busy 1-62.
//  - Same bench with a mac_array model and signed random 8b data -> all 64 psums match the
//    reference dot products K[k].Q[q].
//  - k_reuse=1 with start -> no reads of K_BASE..; inst=10 in cycles 2-9; done in cycle 32.
//  - start pulsed again in cycles 5 and 40 -> no effect; exactly one done; waveform identical
//    to scenario 1.
//  - reset asserted in cycle 20 for 3 cycles, then start -> all outputs 0 during reset; no done;
//    the new pass matches scenario 1 timing relative to its own start.
//  - start held high continuously -> back-to-back passes; the second pass has c=1 two cycles
//    after the first done; done pulses 63 cycles apart.

Source files
------------

// File: rtl/mac_array_seq.sv
// Sequencer that streams K then Q vectors from a 1-cycle-latency vector memory into mac_array,
// framing each phase with the load/execute instruction and idle drain gaps the array expects.
module mac_array_seq #(
  parameter int NUM_K  = 8,
  parameter int NUM_Q  = 8,
  parameter int DRAIN  = 22,
  parameter int AW     = 8,
  parameter int BW     = 64,
  parameter int K_BASE = 0,
  parameter int Q_BASE = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          k_reuse,
  output logic          mem_rd,
  output logic [AW-1:0] mem_addr,
  input  logic [BW-1:0] mem_rdata,
  output logic [BW-1:0] array_in,
  output logic [1:0]    array_inst,
  output logic          busy,
  output logic          done
);

  localparam int MKQ  = (NUM_K > NUM_Q) ? NUM_K : NUM_Q;
  localparam int MAXC = (MKQ > DRAIN) ? MKQ : DRAIN;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [CW-1:0] K_LAST  = CW'(NUM_K - 1);
  localparam logic [CW-1:0] Q_LAST  = CW'(NUM_Q - 1);
  localparam logic [CW-1:0] DK_LAST = CW'(DRAIN - 1);
  // Post-execute drain runs one extra count: the last read's data cycle precedes the idle gap.
  localparam logic [CW-1:0] DQ_LAST = CW'(DRAIN);

  localparam logic [1:0] INST_IDLE = 2'b00;
  localparam logic [1:0] INST_K    = 2'b01;
  localparam logic [1:0] INST_Q    = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_K, S_DRAIN_K, S_EXEC_Q, S_DRAIN_Q, S_DONE
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_rd_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_rd_q     <= 1'b0;
      mem_rd     <= 1'b0;
      mem_addr   <= '0;
      array_in   <= '0;
      array_inst <= INST_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      // inst is the read strobe delayed one cycle; the data it announces lands the cycle after.
      if (array_inst != INST_IDLE) array_in <= mem_rdata;
      array_inst <= mem_rd ? (r_rd_q ? INST_Q : INST_K) : INST_IDLE;

      case (r_state)
        S_IDLE: begin
          if (start) begin
            busy   <= 1'b1;
            mem_rd <= 1'b1;
            r_cnt  <= '0;
            if (k_reuse) begin
              r_state  <= S_EXEC_Q;
              mem_addr <= AW'(Q_BASE);
              r_rd_q   <= 1'b1;
            end else begin
              r_state  <= S_LOAD_K;
              mem_addr <= AW'(K_BASE);
              r_rd_q   <= 1'b0;
            end
          end
        end
        S_LOAD_K: begin
          if (r_cnt == K_LAST) begin
            mem_rd  <= 1'b0;
            r_cnt   <= '0;
            r_state <= S_DRAIN_K;
          end else begin
            r_cnt    <= r_cnt + 1'b1;
            mem_addr <= mem_addr + 1'b1;
          end
        end
        S_DRAIN_K: begin
          if (r_cnt == DK_LAST) begin
            r_cnt    <= '0;
            mem_rd   <= 1'b1;
            mem_addr <= AW'(Q_BASE);
            r_rd_q   <= 1'b1;
            r_state  <= S_EXEC_Q;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_EXEC_Q: begin
          if (r_cnt == Q_LAST) begin
            mem_rd  <= 1'b0;
            r_cnt   <= '0;
            r_state <= S_DRAIN_Q;
          end else begin
            r_cnt    <= r_cnt + 1'b1;
            mem_addr <= mem_addr + 1'b1;
          end
        end
        S_DRAIN_Q: begin
          if (r_cnt == DQ_LAST) begin
            r_cnt   <= '0;
            done    <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_array_seq.sv
// Directed/random bench for mac_array_seq: per-cycle comparison against a cycle-numbered
// reference of the pass schedule, plus a dot-product check of what the array receives.
module tb_mac_array_seq;
  localparam int NK = 8, NQ = 8, DR = 22, AW = 8, BW = 64, KB = 0, QB = 8;

  logic          clk = 1'b0;
  logic          reset, start, k_reuse;
  logic          mem_rd, busy, done;
  logic [AW-1:0] mem_addr;
  logic [BW-1:0] mem_rdata = '0;
  logic [BW-1:0] array_in;
  logic [1:0]    array_inst;

  mac_array_seq #(.NUM_K(NK), .NUM_Q(NQ), .DRAIN(DR), .AW(AW), .BW(BW),
                  .K_BASE(KB), .Q_BASE(QB)) dut (
    .clk(clk), .reset(reset), .start(start), .k_reuse(k_reuse),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .array_in(array_in), .array_inst(array_inst), .busy(busy), .done(done));

  always #5 clk = ~clk;

  logic [BW-1:0] mem [0:255];
  always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];

  int n_chk = 0, n_fail = 0;
  int cyc = 0, c = 0, start_cyc = 0, done_cnt = 0;
  bit m_reuse = 1'b0;
  logic [AW-1:0] e_addr = '0;
  logic [BW-1:0] e_in = '0;
  logic [1:0] prev_inst = 2'b00;
  logic [BW-1:0] kcap[$], qcap[$];
  int done_log[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s (cycle %0d c=%0d): got %h expected %h", tag, cyc, c, obs, exp);
    end
  endtask

  function automatic int dot(input logic [BW-1:0] a, input logic [BW-1:0] b);
    int s = 0;
    logic signed [7:0] x, y;
    for (int l = 0; l < 8; l++) begin
      x = a[l*8 +: 8];
      y = b[l*8 +: 8];
      s += int'(x) * int'(y);
    end
    return s;
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, "_mem_rd"}, 64'(mem_rd), 64'(0));
    chk({tag, "_mem_addr"}, 64'(mem_addr), 64'(0));
    chk({tag, "_array_in"}, 64'(array_in), 64'(0));
    chk({tag, "_array_inst"}, 64'(array_inst), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_done"}, 64'(done), 64'(0));
  endtask

  // One clock: advance the pass-cycle reference, then compare every output.
  task automatic tick();
    logic s, kr, rs, e_rd;
    logic [1:0] e_inst;
    int p, d;
    s = start; kr = k_reuse; rs = reset;
    @(posedge clk); #1; cyc++;
    p = m_reuse ? 2 : NK + 2 + DR;
    d = p + NQ + DR;
    if (rs) begin
      c = 0; e_addr = '0; e_in = '0;
    end else if (c == 0) begin
      if (s) begin c = 1; m_reuse = kr; start_cyc = cyc; end
    end else if (c == d) c = 0;
    else c++;
    p = m_reuse ? 2 : NK + 2 + DR;
    d = p + NQ + DR;
    e_rd = 1'b0; e_inst = 2'b00;
    if (c > 0) begin
      if (!m_reuse && c <= NK) begin e_rd = 1'b1; e_addr = AW'(KB + c - 1); end
      else if (c >= p - 1 && c <= p + NQ - 2) begin e_rd = 1'b1; e_addr = AW'(QB + c - (p - 1)); end
      if (!m_reuse && c >= 2 && c <= NK + 1) e_inst = 2'b01;
      else if (c >= p && c <= p + NQ - 1) e_inst = 2'b10;
      if (!m_reuse && c >= 3 && c <= NK + 2) e_in = mem[KB + c - 3];
      else if (c >= p + 1 && c <= p + NQ) e_in = mem[QB + c - p - 1];
    end
    chk("mem_rd", 64'(mem_rd), 64'(e_rd));
    chk("mem_addr", 64'(mem_addr), 64'(e_addr));
    chk("array_inst", 64'(array_inst), 64'(e_inst));
    chk("array_in", 64'(array_in), 64'(e_in));
    chk("busy", 64'(busy), 64'(c >= 1 && c <= d));
    chk("done", 64'(done), 64'(c == d && c > 0));
    if (done === 1'b1) begin done_cnt++; done_log.push_back(cyc); end
    if (prev_inst == 2'b01) kcap.push_back(array_in);
    if (prev_inst == 2'b10) qcap.push_back(array_in);
    prev_inst = array_inst;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  int d0;

  initial begin
    reset = 1'b1; start = 1'b0; k_reuse = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    for (int i = 0; i < NK; i++) mem[KB + i] = {8{8'(i + 1)}};
    for (int j = 0; j < NQ; j++) mem[QB + j] = {8{8'(8'h10 + j)}};
    #1 check_zero("async_reset");
    run(3);
    reset = 1'b0;
    run(2);

    // Scenario 1: single start pulse, default schedule
    start = 1'b1; tick(); start = 1'b0;
    chk("s1_start_rel", 64'(cyc - start_cyc), 64'(0));
    d0 = done_cnt;
    run(70);
    chk("s1_done_count", 64'(done_cnt - d0), 64'(1));
    chk("s1_done_cycle", 64'(done_log[done_log.size()-1] - start_cyc + 1), 64'(62));

    // Scenario 3: kernel reuse skips the K load
    start = 1'b1; k_reuse = 1'b1; tick(); start = 1'b0; k_reuse = 1'b0;
    d0 = done_cnt;
    run(40);
    chk("s3_done_count", 64'(done_cnt - d0), 64'(1));
    chk("s3_done_cycle", 64'(done_log[done_log.size()-1] - start_cyc + 1), 64'(32));

    // Scenario 4: start re-pulsed mid-pass is ignored; k_reuse flip mid-pass too
    start = 1'b1; tick(); start = 1'b0;
    d0 = done_cnt;
    for (int i = 0; i < 70; i++) begin
      start = (c == 5 || c == 40);
      k_reuse = (c == 10);
      tick();
    end
    start = 1'b0; k_reuse = 1'b0;
    chk("s4_done_count", 64'(done_cnt - d0), 64'(1));

    // Scenario 5: reset mid-pass, then a fresh pass
    start = 1'b1; tick(); start = 1'b0;
    d0 = done_cnt;
    while (c < 20 && c > 0) tick();
    #2 reset = 1'b1;
    #1 check_zero("mid_reset");
    c = 0; e_addr = '0; e_in = '0;
    run(3);
    reset = 1'b0;
    run(5);
    chk("s5_no_done", 64'(done_cnt - d0), 64'(0));
    start = 1'b1; tick(); start = 1'b0;
    run(70);
    chk("s5_restart_done", 64'(done_cnt - d0), 64'(1));

    // Scenario 2: signed random data, array-side dot products
    for (int i = 0; i < NK; i++) mem[KB + i] = {$urandom, $urandom};
    for (int j = 0; j < NQ; j++) mem[QB + j] = {$urandom, $urandom};
    kcap.delete(); qcap.delete();
    start = 1'b1; tick(); start = 1'b0;
    run(70);
    chk("s2_k_count", 64'(kcap.size()), 64'(NK));
    chk("s2_q_count", 64'(qcap.size()), 64'(NQ));
    if (kcap.size() == NK && qcap.size() == NQ)
      for (int k = 0; k < NK; k++)
        for (int q = 0; q < NQ; q++)
          chk($sformatf("psum_k%0d_q%0d", k, q), 64'(dot(kcap[k], qcap[q])),
              64'(dot(mem[KB + k], mem[QB + q])));

    // Scenario 6: start held high -> back-to-back passes
    done_log.delete();
    start = 1'b1;
    run(140);
    start = 1'b0;
    run(70);
    chk("s6_done_count_ge2", 64'(done_log.size() >= 2), 64'(1));
    if (done_log.size() >= 2)
      chk("s6_done_spacing", 64'(done_log[1] - done_log[0]), 64'(63));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
